// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// datapath mux selects and the per-state control word.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        LUI      = 4'd11,
        AUIPC    = 4'd12
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        ALUM_ADD = 2'd0,
        ALUM_SUB = 2'd1,
        ALUM_DEC = 2'd2
    } alu_mode_e;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        alu_mode_e  alu_mode;
        logic       retire;
    } ctrl_t;

    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_ITYPE, OP_JALR: return IMM_I;
            OP_STORE:                   return IMM_S;
            OP_BRANCH:                  return IMM_B;
            OP_JAL:                     return IMM_J;
            OP_LUI, OP_AUIPC:           return IMM_U;
            default:                    return 3'b000;
        endcase
    endfunction

    // jalr has an immediate format but no execution path, so it decodes as unknown.
    function automatic logic is_known(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
            OP_JAL, OP_LUI, OP_AUIPC: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

    function automatic ctrl_t ctrl_of(input state_e s);
        ctrl_t c;
        c = '0;
        c.alu_mode = ALUM_ADD;
        case (s)
            FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_write   = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
            end
            DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
            end
            MEMREAD: c.adr_src = 1'b1;
            MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
                c.retire    = 1'b1;
            end
            EXECR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_mode  = ALUM_DEC;
            end
            EXECI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_mode  = ALUM_DEC;
            end
            LUI: begin
                c.alu_src_a = SRCA_ZERO;
                c.alu_src_b = SRCB_IMM;
            end
            AUIPC: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            JAL: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_write  = 1'b1;
            end
            ALUWB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_mode  = ALUM_SUB;
                c.branch    = 1'b1;
                c.retire    = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and Zero in, mux selects and enables out.
interface multicycle_controller_if;
    logic [6:0] Opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       instr_retired;
    logic [3:0] state_o;

    modport master (
        input  Opcode, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, instr_retired, state_o
    );

    modport slave (
        output Opcode, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, instr_retired, state_o
    );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode from funct3/funct7b5; purely combinational.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] Opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] ALUControl
);
    always_comb begin
        ALUControl = ALU_ADD;
        case (funct3)
            3'b000:  ALUControl = (Opcode == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  ALUControl = ALU_SLT;
            3'b100:  ALUControl = ALU_XOR;
            3'b110:  ALUControl = ALU_OR;
            3'b111:  ALUControl = ALU_AND;
            default: ALUControl = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core; control word is registered from the next state.
// ImmSrc, ALU decode, branch PCWrite and unknown-opcode retire are the only combinational paths.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
);
    state_e     state;
    state_e     nxt;
    ctrl_t      ctrl_q;
    logic [2:0] alu_dec;
    logic       branch_taken;
    logic       unknown_retire;

    function automatic state_e next_of(input state_e s, input logic [6:0] op);
        case (s)
            FETCH: return DECODE;
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: return MEMADR;
                    OP_RTYPE:          return EXECR;
                    OP_ITYPE:          return EXECI;
                    OP_BRANCH:         return BRANCH;
                    OP_JAL:            return JAL;
                    OP_LUI:            return LUI;
                    OP_AUIPC:          return AUIPC;
                    default:           return FETCH;
                endcase
            end
            MEMADR:                       return (op == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD:                      return MEMWB;
            EXECR, EXECI, LUI, AUIPC, JAL: return ALUWB;
            default:                      return FETCH;
        endcase
    endfunction

    assign nxt = next_of(state, bus.Opcode);

    // Reset loads FETCH's control word so the first edge after release performs a fetch;
    // the enables are additionally masked by rst below.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FETCH;
            ctrl_q <= ctrl_of(FETCH);
        end else begin
            state  <= nxt;
            ctrl_q <= ctrl_of(nxt);
        end
    end

    alu_decoder u_alu_decoder (
        .Opcode     (bus.Opcode),
        .funct3     (bus.funct3),
        .funct7b5   (bus.funct7b5),
        .ALUControl (alu_dec)
    );

    assign branch_taken   = ((bus.funct3 == 3'b000) &&  bus.Zero) ||
                            ((bus.funct3 == 3'b001) && !bus.Zero);
    // The IR is only valid once DECODE is entered, so this retire cannot be registered.
    assign unknown_retire = (state == DECODE) && !is_known(bus.Opcode);

    assign bus.PCWrite       = !rst && (ctrl_q.pc_write || (ctrl_q.branch && branch_taken));
    assign bus.IRWrite       = !rst && ctrl_q.ir_write;
    assign bus.MemWrite      = !rst && ctrl_q.mem_write;
    assign bus.RegWrite      = !rst && ctrl_q.reg_write;
    assign bus.instr_retired = !rst && (ctrl_q.retire || unknown_retire);
    assign bus.AdrSrc        = ctrl_q.adr_src;
    assign bus.ResultSrc     = ctrl_q.result_src;
    assign bus.ALUSrcA       = ctrl_q.alu_src_a;
    assign bus.ALUSrcB       = ctrl_q.alu_src_b;
    assign bus.ImmSrc        = imm_src_of(bus.Opcode);
    assign bus.state_o       = state;

    always_comb begin
        bus.ALUControl = ALU_ADD;
        case (ctrl_q.alu_mode)
            ALUM_SUB: bus.ALUControl = ALU_SUB;
            ALUM_DEC: bus.ALUControl = alu_dec;
            default:  bus.ALUControl = ALU_ADD;
        endcase
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed per-cycle checks of the multicycle controller's full control word.
module tb_multicycle_controller;
    import riscv_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, instr_retired}
    function automatic logic [21:0] ev(input state_e s, input logic pcw, input logic adr,
                                       input logic mw, input logic irw, input logic rw,
                                       input logic [1:0] res, input logic [1:0] a,
                                       input logic [1:0] b, input logic [2:0] imm,
                                       input logic [2:0] alu, input logic ret);
        return {s, pcw, adr, mw, irw, rw, res, a, b, imm, alu, ret};
    endfunction

    function automatic logic [21:0] obs();
        return {bus.state_o, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl,
                bus.instr_retired};
    endfunction

    function automatic logic [21:0] v_fetch(input logic [2:0] imm);
        return ev(FETCH, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0);
    endfunction

    function automatic logic [21:0] v_decode(input logic [2:0] imm, input logic ret);
        return ev(DECODE, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, ret);
    endfunction

    function automatic logic [21:0] v_aluwb(input logic [2:0] imm);
        return ev(ALUWB, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1);
    endfunction

    task automatic chk(input string tag, input logic [21:0] exp);
        logic [21:0] o;
        o = obs();
        vectors++;
        assert (o === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, o, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        bus.Opcode   = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        bus.Zero     = z;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        #12;
        chk("reset_hold", ev(FETCH, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0));
        #1 rst = 1'b0;
        #1;
        // lw: 5 cycles
        chk("lw_fetch", v_fetch(3'b000));
        step(); chk("lw_decode", v_decode(3'b000, 0));
        step(); chk("lw_memadr", ev(MEMADR, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
        step(); chk("lw_memread", ev(MEMREAD, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        step(); chk("lw_memwb", ev(MEMWB, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1));

        // sw: 4 cycles
        step(); set_instr(7'b0100011, 3'b010, 1'b0, 1'b0); #1;
        chk("sw_fetch", v_fetch(3'b001));
        step(); chk("sw_decode", v_decode(3'b001, 0));
        step(); chk("sw_memadr", ev(MEMADR, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 3'b000, 0));
        step(); chk("sw_memwrite", ev(MEMWRITE, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b001, 3'b000, 1));

        // beq taken
        step(); set_instr(7'b1100011, 3'b000, 1'b0, 1'b1); #1;
        chk("beq_fetch", v_fetch(3'b010));
        step(); chk("beq_decode", v_decode(3'b010, 0));
        step(); chk("beq_branch_z1", ev(BRANCH, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 3'b001, 1));
        bus.Zero = 1'b0; #1;
        chk("beq_branch_z0", ev(BRANCH, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 3'b001, 1));

        // bne: not taken with Zero=1, taken with Zero=0, never taken for funct3=100
        step(); set_instr(7'b1100011, 3'b001, 1'b0, 1'b1); #1;
        chk("bne_fetch", v_fetch(3'b010));
        step(); chk("bne_decode", v_decode(3'b010, 0));
        step(); chk("bne_branch_z1", ev(BRANCH, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 3'b001, 1));
        bus.Zero = 1'b0; #1;
        chk("bne_branch_z0", ev(BRANCH, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 3'b001, 1));
        bus.funct3 = 3'b100; #1;
        chk("blt_branch_off", ev(BRANCH, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 3'b001, 1));

        // R-type sub
        step(); set_instr(7'b0110011, 3'b000, 1'b1, 1'b0); #1;
        chk("sub_fetch", v_fetch(3'b000));
        step(); chk("sub_decode", v_decode(3'b000, 0));
        step(); chk("sub_execr", ev(EXECR, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 0));
        bus.funct3 = 3'b100; #1;
        chk("xor_execr", ev(EXECR, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b100, 0));
        bus.funct3 = 3'b000;
        step(); chk("sub_aluwb", v_aluwb(3'b000));

        // I-type with the same fields: funct7b5 must not select sub
        step(); set_instr(7'b0010011, 3'b000, 1'b1, 1'b0); #1;
        chk("addi_fetch", v_fetch(3'b000));
        step(); chk("addi_decode", v_decode(3'b000, 0));
        step(); chk("addi_execi", ev(EXECI, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
        bus.funct3 = 3'b010; #1;
        chk("slti_execi", ev(EXECI, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b101, 0));
        bus.funct3 = 3'b110; #1;
        chk("ori_execi", ev(EXECI, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b011, 0));
        bus.funct3 = 3'b111; #1;
        chk("andi_execi", ev(EXECI, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b010, 0));
        step(); chk("addi_aluwb", v_aluwb(3'b000));

        // jal
        step(); set_instr(7'b1101111, 3'b000, 1'b0, 1'b0); #1;
        chk("jal_fetch", v_fetch(3'b011));
        step(); chk("jal_decode", v_decode(3'b011, 0));
        step(); chk("jal_jal", ev(JAL, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b011, 3'b000, 0));
        step(); chk("jal_aluwb", v_aluwb(3'b011));

        // lui
        step(); set_instr(7'b0110111, 3'b000, 1'b0, 1'b0); #1;
        chk("lui_fetch", v_fetch(3'b100));
        step(); chk("lui_decode", v_decode(3'b100, 0));
        step(); chk("lui_lui", ev(LUI, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 3'b100, 3'b000, 0));
        step(); chk("lui_aluwb", v_aluwb(3'b100));

        // auipc
        step(); set_instr(7'b0010111, 3'b000, 1'b0, 1'b0); #1;
        chk("auipc_fetch", v_fetch(3'b100));
        step(); chk("auipc_decode", v_decode(3'b100, 0));
        step(); chk("auipc_auipc", ev(AUIPC, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b100, 3'b000, 0));
        step(); chk("auipc_aluwb", v_aluwb(3'b100));

        // unknown opcode: 2 cycles, retire in DECODE, no writes
        step(); set_instr(7'b1111111, 3'b000, 1'b0, 1'b0); #1;
        chk("unk_fetch", v_fetch(3'b000));
        step(); chk("unk_decode", v_decode(3'b000, 1));
        step(); chk("unk_refetch", v_fetch(3'b000));

        // reset during MEMWRITE aborts the store without a clock edge
        set_instr(7'b0100011, 3'b010, 1'b0, 1'b0); #1;
        step(); chk("abort_decode", v_decode(3'b001, 0));
        step(); chk("abort_memadr", ev(MEMADR, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 3'b000, 0));
        step(); chk("abort_memwrite", ev(MEMWRITE, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b001, 3'b000, 1));
        #2 rst = 1'b1;
        #1 chk("abort_async", ev(FETCH, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b001, 3'b000, 0));
        #2 rst = 1'b0;
        #1 chk("abort_release_fetch", v_fetch(3'b001));
        step(); chk("abort_restart_decode", v_decode(3'b001, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
